// File: rtl/phv_stage_fifo.sv
// Elastic PHV buffer between match-action stages: FWFT FIFO with registered head,
// almost-full upstream indication, saturating drop/pass counters and control-packet flush/clear.
module phv_stage_fifo #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned STAGE_ID             = 0,
    parameter int unsigned PHV_LEN              = 1124,
    parameter int unsigned DEPTH                = 4,
    parameter int unsigned AF_MARGIN            = 1
) (
    input  logic                                  axis_clk,
    input  logic                                  areset,

    input  logic [PHV_LEN-1:0]                    phv_in,
    input  logic                                  phv_in_valid,
    output logic                                  stg_ready,

    output logic [PHV_LEN-1:0]                    phv_out,
    output logic                                  phv_out_valid,
    input  logic                                  phv_out_ready,

    output logic [31:0]                           drop_cnt,
    output logic [31:0]                           pass_cnt,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]        c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]       c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]      c_s_axis_tkeep,
    input  logic                                  c_s_axis_tvalid,
    input  logic                                  c_s_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]        c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]       c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]      c_m_axis_tkeep,
    output logic                                  c_m_axis_tvalid,
    output logic                                  c_m_axis_tlast
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
    localparam logic [CW-1:0] AfCnt   = CW'(DEPTH - AF_MARGIN);
    localparam logic [7:0]    StageId = 8'(STAGE_ID);
    localparam logic [7:0]    OpFlush = 8'h01;
    localparam logic [7:0]    OpClr   = 8'h02;
    localparam logic [31:0]   CntMax  = 32'hFFFF_FFFF;

    logic [PHV_LEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
    logic               stg_ready_q;
    logic [31:0]        drop_cnt_q, drop_cnt_d, pass_cnt_q, pass_cnt_d;
    logic               sop_q, sop_d;

    logic [C_S_AXIS_DATA_WIDTH-1:0]  c_tdata_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] c_tuser_q;
    logic [KW-1:0]                   c_tkeep_q;
    logic                            c_tvalid_q, c_tlast_q;

    logic full, pop, push, drop, is_hdr, flush, clr;

    always_comb begin
        full   = (count_q == FullCnt);
        pop    = (count_q != '0) && phv_out_ready;
        push   = phv_in_valid && (!full || pop);
        drop   = phv_in_valid && full && !pop;
        is_hdr = c_s_axis_tvalid && sop_q && (c_s_axis_tdata[7:0] == StageId);
        flush  = is_hdr && (c_s_axis_tdata[15:8] == OpFlush);
        clr    = is_hdr && (c_s_axis_tdata[15:8] == OpClr);
        sop_d  = c_s_axis_tvalid ? c_s_axis_tlast : sop_q;

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // The next head is the incoming PHV only when it lands in an otherwise empty FIFO.
        phv_out_d = '0;
        if (count_d != '0) begin
            phv_out_d = (push && (rd_ptr_d == wr_ptr_q)) ? phv_in : mem_q[rd_ptr_d];
        end

        drop_cnt_d = drop_cnt_q;
        pass_cnt_d = pass_cnt_q;
        if (clr) begin
            drop_cnt_d = '0;
            pass_cnt_d = '0;
        end else if (!flush) begin
            if (drop && (drop_cnt_q != CntMax)) drop_cnt_d = drop_cnt_q + 32'd1;
            if (pop && (pass_cnt_q != CntMax)) pass_cnt_d = pass_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= phv_in;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            phv_out_q   <= '0;
            stg_ready_q <= 1'b1;
            drop_cnt_q  <= '0;
            pass_cnt_q  <= '0;
            sop_q       <= 1'b1;
            c_tdata_q   <= '0;
            c_tuser_q   <= '0;
            c_tkeep_q   <= '0;
            c_tvalid_q  <= 1'b0;
            c_tlast_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            phv_out_q   <= phv_out_d;
            stg_ready_q <= (count_d < AfCnt);
            drop_cnt_q  <= drop_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            sop_q       <= sop_d;
            c_tdata_q   <= c_s_axis_tdata;
            c_tuser_q   <= c_s_axis_tuser;
            c_tkeep_q   <= c_s_axis_tkeep;
            c_tvalid_q  <= c_s_axis_tvalid;
            c_tlast_q   <= c_s_axis_tlast;
        end
    end

    assign stg_ready       = stg_ready_q;
    assign phv_out         = phv_out_q;
    assign phv_out_valid   = (count_q != '0);
    assign drop_cnt        = drop_cnt_q;
    assign pass_cnt        = pass_cnt_q;
    assign c_m_axis_tdata  = c_tdata_q;
    assign c_m_axis_tuser  = c_tuser_q;
    assign c_m_axis_tkeep  = c_tkeep_q;
    assign c_m_axis_tvalid = c_tvalid_q;
    assign c_m_axis_tlast  = c_tlast_q;

endmodule

// File: tb/tb_phv_stage_fifo.sv
// Directed bench for phv_stage_fifo: stimulus pushes expected PHVs and control beats into
// queues; negedge monitors pop and compare whenever the DUT presents them.
module tb_phv_stage_fifo;

    localparam int unsigned PL  = 1124;
    localparam int unsigned DW  = 512;
    localparam int unsigned UW  = 128;
    localparam int unsigned KW  = 64;
    localparam int unsigned SID = 5;

    typedef logic [PL-1:0] phv_t;
    typedef struct packed {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          areset;
    phv_t          phv_in, phv_out;
    logic          phv_in_valid, stg_ready, phv_out_valid, phv_out_ready;
    logic [31:0]   drop_cnt, pass_cnt;
    logic [DW-1:0] s_tdata, m_tdata;
    logic [UW-1:0] s_tuser, m_tuser;
    logic [KW-1:0] s_tkeep, m_tkeep;
    logic          s_tvalid, s_tlast, m_tvalid, m_tlast;

    int    total = 0;
    int    bad   = 0;
    phv_t  exp_phv [$];
    beat_t exp_ctl [$];
    phv_t  mon_p;
    beat_t mon_b;
    phv_t  tmp;

    always #5 clk = ~clk;

    phv_stage_fifo #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .STAGE_ID            (SID),
        .PHV_LEN             (PL),
        .DEPTH               (4),
        .AF_MARGIN           (1)
    ) dut (
        .axis_clk       (clk),
        .areset         (areset),
        .phv_in         (phv_in),
        .phv_in_valid   (phv_in_valid),
        .stg_ready      (stg_ready),
        .phv_out        (phv_out),
        .phv_out_valid  (phv_out_valid),
        .phv_out_ready  (phv_out_ready),
        .drop_cnt       (drop_cnt),
        .pass_cnt       (pass_cnt),
        .c_s_axis_tdata (s_tdata),
        .c_s_axis_tuser (s_tuser),
        .c_s_axis_tkeep (s_tkeep),
        .c_s_axis_tvalid(s_tvalid),
        .c_s_axis_tlast (s_tlast),
        .c_m_axis_tdata (m_tdata),
        .c_m_axis_tuser (m_tuser),
        .c_m_axis_tkeep (m_tkeep),
        .c_m_axis_tvalid(m_tvalid),
        .c_m_axis_tlast (m_tlast)
    );

    function automatic phv_t mk(int unsigned v);
        phv_t p;
        p = phv_t'(v) | (phv_t'(v) << (PL - 32));
        return p;
    endfunction

    function automatic beat_t mkb(logic [7:0] op, logic [7:0] id, logic last, int unsigned tag);
        beat_t b;
        b.d = (DW'(tag) << 32) | DW'({op, id});
        b.u = UW'(tag * 3 + 1);
        b.k = ~KW'(tag);
        b.l = last;
        return b;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(beat_t b, bit expect_out);
        s_tdata  = b.d;
        s_tuser  = b.u;
        s_tkeep  = b.k;
        s_tlast  = b.l;
        s_tvalid = 1'b1;
        if (expect_out) exp_ctl.push_back(b);
    endtask

    task automatic idle_ctl();
        s_tdata  = '0;
        s_tuser  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
    endtask

    task automatic push_phv(int unsigned v, bit expect_out);
        phv_in       = mk(v);
        phv_in_valid = 1'b1;
        if (expect_out) exp_phv.push_back(mk(v));
        cyc();
        phv_in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_stg_ready"}, 64'(stg_ready), 64'd1);
        chk({tag, "_valid"}, 64'(phv_out_valid), 64'd0);
        chk({tag, "_phv_out"}, phv_out[63:0], 64'd0);
        chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
        chk({tag, "_pass"}, 64'(pass_cnt), 64'd0);
        chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({tag, "_m_tdata"}, m_tdata[63:0], 64'd0);
    endtask

    // PHV monitor: every handshake must match the oldest expected PHV.
    always @(negedge clk) begin
        if (phv_out_valid === 1'b1 && phv_out_ready === 1'b1) begin
            total++;
            if (exp_phv.size() == 0) begin
                bad++;
                $display("FAIL phv_unexpected: got %0h want none", phv_out[63:0]);
            end else begin
                mon_p = exp_phv.pop_front();
                if (phv_out !== mon_p) begin
                    bad++;
                    $display("FAIL phv_data: got %0h want %0h", phv_out, mon_p);
                end
            end
        end
    end

    // Control monitor: every c_m beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (m_tvalid === 1'b1) begin
            total++;
            if (exp_ctl.size() == 0) begin
                bad++;
                $display("FAIL ctl_unexpected: got %0h want none", m_tdata[63:0]);
            end else begin
                mon_b = exp_ctl.pop_front();
                if ({m_tdata, m_tuser, m_tkeep, m_tlast} !== mon_b) begin
                    bad++;
                    $display("FAIL ctl_beat: got %0h want %0h",
                             {m_tdata[63:0], m_tuser[31:0], m_tkeep, m_tlast},
                             {mon_b.d[63:0], mon_b.u[31:0], mon_b.k, mon_b.l});
                end
            end
        end
    end

    initial begin
        areset        = 1'b1;
        phv_in        = '0;
        phv_in_valid  = 1'b0;
        phv_out_ready = 1'b0;
        idle_ctl();
        cyc(2);
        areset = 1'b0;
        chk_reset_vals("rst");

        // Streaming at full rate: each PHV is the head one cycle after it is pushed.
        phv_out_ready = 1'b1;
        for (int v = 1; v <= 10; v++) begin
            push_phv(v, 1'b1);
            tmp = mk(v);
            chk("t1_latency", phv_out[63:0], tmp[63:0]);
        end
        cyc(2);
        chk("t1_pass", 64'(pass_cnt), 64'd10);
        chk("t1_drop", 64'(drop_cnt), 64'd0);

        // Backpressure: fill, then overflow drops two.
        phv_out_ready = 1'b0;
        for (int v = 11; v <= 16; v++) begin
            push_phv(v, v <= 14);
            if (v == 12) chk("t2_ready_at2", 64'(stg_ready), 64'd1);
            if (v == 13) chk("t2_ready_at3", 64'(stg_ready), 64'd0);
        end
        chk("t2_drop", 64'(drop_cnt), 64'd2);
        tmp = mk(11);
        chk("t2_head_stable", phv_out[63:0], tmp[63:0]);
        phv_out_ready = 1'b1;
        cyc(6);
        chk("t2_pass", 64'(pass_cnt), 64'd14);
        chk("t2_ready_back", 64'(stg_ready), 64'd1);

        // Full FIFO with simultaneous push and pop.
        phv_out_ready = 1'b0;
        for (int v = 21; v <= 24; v++) push_phv(v, 1'b1);
        phv_out_ready = 1'b1;
        push_phv(25, 1'b1);
        phv_out_ready = 1'b0;
        chk("t3_drop", 64'(drop_cnt), 64'd2);
        chk("t3_still_full", 64'(stg_ready), 64'd0);
        tmp = mk(22);
        chk("t3_head", phv_out[63:0], tmp[63:0]);
        phv_out_ready = 1'b1;
        cyc(6);
        chk("t3_pass", 64'(pass_cnt), 64'd19);

        // Flush with three held and a same-cycle push.
        phv_out_ready = 1'b0;
        for (int v = 31; v <= 33; v++) push_phv(v, 1'b0);
        drive_beat(mkb(8'h01, 8'(SID), 1'b0, 7), 1'b1);
        phv_in       = mk(34);
        phv_in_valid = 1'b1;
        cyc();
        idle_ctl();
        phv_in_valid = 1'b0;
        #1;
        chk("t4_echo_valid", 64'(m_tvalid), 64'd1);
        chk("t4_echo_data", m_tdata[63:0], {32'd7, 16'd0, 8'h01, 8'(SID)});
        chk("t4_flushed", 64'(phv_out_valid), 64'd0);
        chk("t4_drop", 64'(drop_cnt), 64'd2);
        chk("t4_pass", 64'(pass_cnt), 64'd19);
        chk("t4_ready", 64'(stg_ready), 64'd1);
        // A flush opcode in a non-header beat must be ignored.
        push_phv(41, 1'b1);
        drive_beat(mkb(8'h01, 8'(SID), 1'b1, 8), 1'b1);
        cyc();
        idle_ctl();
        chk("t4_midpkt_ignored", 64'(phv_out_valid), 64'd1);
        phv_out_ready = 1'b1;
        cyc(2);
        chk("t4_pass41", 64'(pass_cnt), 64'd20);

        // Clear: foreign ID ignored, own ID during a pop wins.
        phv_out_ready = 1'b0;
        drive_beat(mkb(8'h02, 8'd9, 1'b1, 9), 1'b1);
        cyc();
        idle_ctl();
        chk("t5_foreign_drop", 64'(drop_cnt), 64'd2);
        chk("t5_foreign_pass", 64'(pass_cnt), 64'd20);
        push_phv(51, 1'b1);
        phv_out_ready = 1'b1;
        drive_beat(mkb(8'h02, 8'(SID), 1'b1, 10), 1'b1);
        cyc();
        idle_ctl();
        phv_out_ready = 1'b0;
        chk("t5_clr_drop", 64'(drop_cnt), 64'd0);
        chk("t5_clr_pass", 64'(pass_cnt), 64'd0);
        chk("t5_popped", 64'(phv_out_valid), 64'd0);

        // Reset in the middle of a control packet and a PHV burst.
        push_phv(61, 1'b0);
        push_phv(62, 1'b0);
        drive_beat(mkb(8'h01, 8'd9, 1'b0, 11), 1'b1);
        cyc();
        areset = 1'b1;
        drive_beat(mkb(8'h00, 8'd0, 1'b0, 12), 1'b0);
        phv_in       = mk(63);
        phv_in_valid = 1'b1;
        cyc();
        areset       = 1'b0;
        phv_in_valid = 1'b0;
        idle_ctl();
        chk_reset_vals("t6");
        push_phv(71, 1'b0);
        chk("t6_held", 64'(phv_out_valid), 64'd1);
        drive_beat(mkb(8'h01, 8'(SID), 1'b1, 13), 1'b1);
        cyc();
        idle_ctl();
        chk("t6_hdr_after_reset", 64'(phv_out_valid), 64'd0);
        cyc(3);

        chk("phv_queue_drained", 64'(exp_phv.size()), 64'd0);
        chk("ctl_queue_drained", 64'(exp_ctl.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
